// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port unified instruction/data memory between the fetch
// (IF) stage and the memory (MEM) stage. Only one transaction is in flight at a
// time. The data side wins arbitration by default because it belongs to the
// older instruction.
//
// Transaction sequence: IDLE -> ACCESS -> WAIT (MEM_LAT cycles) -> RESP -> IDLE.
// A request seen in IDLE at cycle 0 is acknowledged at cycle MEM_LAT+2.
//
// Optional feature (compile-time macro MEM_PORT_ARBITER_STARVE_GUARD_EN):
//   After MAX_WAIT consecutive data grants made while a fetch was pending, the
//   next arbitration goes to the fetch side even if data is also requesting.
//   With the macro undefined, data priority is strict and no starve counter
//   exists.
//
// Parameters:
//   AW        address width
//   DW        data width
//   MEM_LAT   memory read latency (mem_en cycle to valid mem_rdata), 1..15
//   MAX_WAIT  data grants tolerated while a fetch waits (guard only), 1..15
//
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   if_req/if_addr       fetch request, held until if_ack
//   if_ack/if_rdata      fetch completion pulse and instruction word
//   d_req/d_we/d_addr/d_wdata  data request (load/JM read or store)
//   d_ack/d_rdata        data completion pulse and load data
//   mem_en/mem_we/mem_addr/mem_wdata  memory strobe, write enable, addr, data
//   mem_rdata            memory read data, valid MEM_LAT cycles after mem_en
//   busy                 high whenever the arbiter is not IDLE
//   owner                0 = fetch, 1 = data; current or most recent grant
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MEM_LAT  = 2,
    parameter int MAX_WAIT = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          owner
);

    // A configuration outside the supported ranges degrades to a single-cycle
    // wait rather than loading a counter value that could never expire cleanly.
    localparam bit CFG_OK_C = (MEM_LAT >= 1) && (MEM_LAT <= 15) &&
                              (MAX_WAIT >= 1) && (MAX_WAIT <= 15);
    localparam logic [3:0] LAT_C = CFG_OK_C ? 4'(MEM_LAT) : 4'd1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [3:0]  cnt_r;
    logic        is_write_r;
    logic        grant_data_s;
    logic        grant_fetch_s;
    logic        force_fetch_s;
    logic        last_wait_s;

`ifdef MEM_PORT_ARBITER_STARVE_GUARD_EN
    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
    logic [3:0] starve_r;

    // Fetch overrides data once it has been passed over MAX_WAIT times in a row.
    assign force_fetch_s = if_req && (starve_r == MAX_WAIT_C);
`else
    assign force_fetch_s = 1'b0;
`endif

    // The final WAIT cycle is where read data is captured and the ack is armed.
    assign last_wait_s = (state_r == WAIT) && (cnt_r == 4'd1);

    // Next-state and arbitration decode.
    always_comb begin
        state_nxt_s   = state_r;
        grant_data_s  = 1'b0;
        grant_fetch_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (d_req && !force_fetch_s) begin
                    grant_data_s = 1'b1;
                    state_nxt_s  = ACCESS;
                end else if (if_req) begin
                    grant_fetch_s = 1'b1;
                    state_nxt_s   = ACCESS;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCESS: begin
                state_nxt_s = WAIT;
            end
            WAIT: begin
                if (cnt_r == 4'd1) begin
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            RESP: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register and latency counter (loaded in ACCESS, counts down in WAIT).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            case (state_r)
                ACCESS:  cnt_r <= LAT_C;
                WAIT:    cnt_r <= cnt_r - 4'd1;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Memory-side outputs: strobe for the ACCESS cycle only, address/data held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= {AW{1'b0}};
            mem_wdata  <= {DW{1'b0}};
            owner      <= 1'b0;
            is_write_r <= 1'b0;
        end else begin
            mem_en <= grant_data_s | grant_fetch_s;
            mem_we <= grant_data_s & d_we;
            if (grant_data_s) begin
                mem_addr   <= d_addr;
                mem_wdata  <= d_wdata;
                owner      <= 1'b1;
                is_write_r <= d_we;
            end else if (grant_fetch_s) begin
                // A fetch carries no write data; mem_wdata keeps its last value.
                mem_addr   <= if_addr;
                owner      <= 1'b0;
                is_write_r <= 1'b0;
            end else begin
                mem_addr   <= mem_addr;
                owner      <= owner;
                is_write_r <= is_write_r;
            end
        end
    end

    // Requester-side responses: read-data capture, ack pulses and busy flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_ack   <= 1'b0;
            d_ack    <= 1'b0;
            if_rdata <= {DW{1'b0}};
            d_rdata  <= {DW{1'b0}};
            busy     <= 1'b0;
        end else begin
            if_ack <= last_wait_s & ~owner;
            d_ack  <= last_wait_s & owner;
            busy   <= (state_nxt_s != IDLE);
            if (last_wait_s && !owner) begin
                if_rdata <= mem_rdata;
            end
            // Stores complete through the same path but leave d_rdata alone.
            if (last_wait_s && owner && !is_write_r) begin
                d_rdata <= mem_rdata;
            end
        end
    end

`ifdef MEM_PORT_ARBITER_STARVE_GUARD_EN
    // Starve counter: counts data grants that overtook a pending fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_r <= 4'd0;
        end else if (grant_fetch_s) begin
            starve_r <= 4'd0;
        end else if (grant_data_s) begin
            if (if_req) begin
                starve_r <= starve_r + 4'd1;
            end else begin
                starve_r <= 4'd0;
            end
        end else begin
            starve_r <= starve_r;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed self-checking bench. Instance A uses MEM_LAT=2, instance B uses
// MEM_LAT=1 for the back-to-back fetch scenario. A small memory model returns
// read data exactly MEM_LAT cycles after the mem_en cycle and garbage
// otherwise, so mistimed capture is visible.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    int          checks;
    int          failures;
    int          cyc;

    // Instance A signals (MEM_LAT = 2)
    logic        if_req_a, d_req_a, d_we_a;
    logic [31:0] if_addr_a, d_addr_a, d_wdata_a;
    logic        if_ack_a, d_ack_a, mem_en_a, mem_we_a, busy_a, owner_a;
    logic [31:0] if_rdata_a, d_rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;

    // Instance B signals (MEM_LAT = 1)
    logic        if_req_b, d_req_b, d_we_b;
    logic [31:0] if_addr_b, d_addr_b, d_wdata_b;
    logic        if_ack_b, d_ack_b, mem_en_b, mem_we_b, busy_b, owner_b;
    logic [31:0] if_rdata_b, d_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;

    logic [31:0] pipe_a0, pipe_a1, pipe_b0;

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(2), .MAX_WAIT(2)) dut_a (
        .clk(clk), .reset(reset),
        .if_req(if_req_a), .if_addr(if_addr_a), .if_ack(if_ack_a), .if_rdata(if_rdata_a),
        .d_req(d_req_a), .d_we(d_we_a), .d_addr(d_addr_a), .d_wdata(d_wdata_a),
        .d_ack(d_ack_a), .d_rdata(d_rdata_a),
        .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
        .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a),
        .busy(busy_a), .owner(owner_a)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .MAX_WAIT(2)) dut_b (
        .clk(clk), .reset(reset),
        .if_req(if_req_b), .if_addr(if_addr_b), .if_ack(if_ack_b), .if_rdata(if_rdata_b),
        .d_req(d_req_b), .d_we(d_we_b), .d_addr(d_addr_b), .d_wdata(d_wdata_b),
        .d_ack(d_ack_b), .d_rdata(d_rdata_b),
        .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b),
        .busy(busy_b), .owner(owner_b)
    );

    // Memory contents as a pure function of address.
    function automatic logic [31:0] mem_fn(input logic [31:0] addr);
        if (addr == 32'h0000_0010) begin
            return 32'hDEAD_BEEF;
        end else begin
            return {addr[15:0], 16'hC0DE};
        end
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Read pipeline: data appears MEM_LAT cycles after the mem_en cycle.
    always @(posedge clk) begin
        pipe_a0 <= (mem_en_a && !mem_we_a) ? mem_fn(mem_addr_a) : 32'hBADB_AD00;
        pipe_a1 <= pipe_a0;
        pipe_b0 <= (mem_en_b && !mem_we_b) ? mem_fn(mem_addr_b) : 32'hBADB_AD00;
    end
    assign mem_rdata_a = pipe_a1;
    assign mem_rdata_b = pipe_b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    int          n;
    int          last_cyc;
    logic [31:0] exp_owner;

    initial begin
        checks = 0; failures = 0; cyc = 0;
        reset = 1'b1;
        if_req_a = 1'b0; d_req_a = 1'b0; d_we_a = 1'b0;
        if_addr_a = 32'h0; d_addr_a = 32'h0; d_wdata_a = 32'h0;
        if_req_b = 1'b0; d_req_b = 1'b0; d_we_b = 1'b0;
        if_addr_b = 32'h0; d_addr_b = 32'h0; d_wdata_b = 32'h0;

        // Reset values
        tick(2);
        check_eq("rst_busy", {31'd0, busy_a}, 32'd0);
        check_eq("rst_owner", {31'd0, owner_a}, 32'd0);
        check_eq("rst_mem_en", {31'd0, mem_en_a}, 32'd0);
        check_eq("rst_mem_addr", mem_addr_a, 32'd0);
        check_eq("rst_acks", {30'd0, if_ack_a, d_ack_a}, 32'd0);
        check_eq("rst_rdata", if_rdata_a | d_rdata_a, 32'd0);
        reset = 1'b0;
        tick(1);

        // Single fetch
        if_req_a = 1'b1; if_addr_a = 32'h10;
        tick(1);
        check_eq("f_mem_en", {31'd0, mem_en_a}, 32'd1);
        check_eq("f_mem_addr", mem_addr_a, 32'h10);
        check_eq("f_mem_we", {31'd0, mem_we_a}, 32'd0);
        check_eq("f_busy1", {31'd0, busy_a}, 32'd1);
        tick(1);
        check_eq("f_mem_en_drop", {31'd0, mem_en_a}, 32'd0);
        tick(1);
        check_eq("f_no_early_ack", {31'd0, if_ack_a}, 32'd0);
        check_eq("f_busy3", {31'd0, busy_a}, 32'd1);
        tick(1);
        check_eq("f_if_ack", {31'd0, if_ack_a}, 32'd1);
        check_eq("f_if_rdata", if_rdata_a, 32'hDEAD_BEEF);
        check_eq("f_busy4", {31'd0, busy_a}, 32'd1);
        if_req_a = 1'b0;
        tick(1);
        check_eq("f_ack_pulse", {31'd0, if_ack_a}, 32'd0);
        check_eq("f_idle", {31'd0, busy_a}, 32'd0);

        // Simultaneous fetch and load: data first
        if_req_a = 1'b1; if_addr_a = 32'h04;
        d_req_a = 1'b1; d_we_a = 1'b0; d_addr_a = 32'h80;
        tick(1);
        check_eq("s_data_addr", mem_addr_a, 32'h80);
        check_eq("s_owner_d", {31'd0, owner_a}, 32'd1);
        tick(3);
        check_eq("s_d_ack", {31'd0, d_ack_a}, 32'd1);
        check_eq("s_d_rdata", d_rdata_a, 32'h0080_C0DE);
        check_eq("s_no_if_ack", {31'd0, if_ack_a}, 32'd0);
        d_req_a = 1'b0;
        tick(1);
        check_eq("s_idle_gap", {31'd0, busy_a}, 32'd0);
        tick(1);
        check_eq("s_fetch_en", {31'd0, mem_en_a}, 32'd1);
        check_eq("s_fetch_addr", mem_addr_a, 32'h04);
        check_eq("s_owner_f", {31'd0, owner_a}, 32'd0);
        tick(3);
        check_eq("s_if_ack", {31'd0, if_ack_a}, 32'd1);
        check_eq("s_if_rdata", if_rdata_a, 32'h0004_C0DE);
        check_eq("s_d_rdata_hold", d_rdata_a, 32'h0080_C0DE);
        if_req_a = 1'b0;
        tick(1);

        // Store
        d_req_a = 1'b1; d_we_a = 1'b1; d_addr_a = 32'h20; d_wdata_a = 32'h55;
        tick(1);
        check_eq("w_mem_en_we", {30'd0, mem_en_a, mem_we_a}, 32'd3);
        check_eq("w_mem_addr", mem_addr_a, 32'h20);
        check_eq("w_mem_wdata", mem_wdata_a, 32'h55);
        tick(1);
        check_eq("w_we_drop", {30'd0, mem_en_a, mem_we_a}, 32'd0);
        tick(2);
        check_eq("w_d_ack", {31'd0, d_ack_a}, 32'd1);
        check_eq("w_d_rdata_keep", d_rdata_a, 32'h0080_C0DE);
        d_req_a = 1'b0; d_we_a = 1'b0;
        tick(1);

        // Reset during the second WAIT cycle of a load
        d_req_a = 1'b1; d_addr_a = 32'h30;
        tick(3);
        reset = 1'b1;
        #1;
        check_eq("r_async_busy", {31'd0, busy_a}, 32'd0);
        check_eq("r_async_outs", mem_addr_a | d_rdata_a | if_rdata_a | mem_wdata_a, 32'd0);
        check_eq("r_async_flags", {28'd0, mem_en_a, owner_a, d_ack_a, if_ack_a}, 32'd0);
        @(posedge clk); #1;
        check_eq("r_no_ack1", {31'd0, d_ack_a}, 32'd0);
        tick(1);
        check_eq("r_no_ack2", {31'd0, d_ack_a}, 32'd0);
        reset = 1'b0;
        tick(1);
        check_eq("r_restart_en", {31'd0, mem_en_a}, 32'd1);
        check_eq("r_restart_addr", mem_addr_a, 32'h30);
        tick(3);
        check_eq("r_d_ack", {31'd0, d_ack_a}, 32'd1);
        check_eq("r_d_rdata", d_rdata_a, 32'h0030_C0DE);
        d_req_a = 1'b0;
        tick(1);

        // Continuous data and fetch requests: grant order
        d_req_a = 1'b1; d_we_a = 1'b0; d_addr_a = 32'h40;
        if_req_a = 1'b1; if_addr_a = 32'h08;
        for (int g = 0; g < 6; g++) begin
            n = 0;
            while (!mem_en_a && n < 12) begin
                tick(1);
                n = n + 1;
            end
            check_eq("sv_grant_seen", {31'd0, mem_en_a}, 32'd1);
`ifdef MEM_PORT_ARBITER_STARVE_GUARD_EN
            exp_owner = ((g % 3) == 2) ? 32'd0 : 32'd1;
`else
            exp_owner = 32'd1;
`endif
            check_eq($sformatf("sv_owner%0d", g), {31'd0, owner_a}, exp_owner);
            check_eq($sformatf("sv_addr%0d", g), mem_addr_a,
                     (exp_owner == 32'd1) ? 32'h40 : 32'h08);
            if (g == 5) begin
                d_req_a = 1'b0;
                if_req_a = 1'b0;
            end
            tick(1);
        end
        tick(3);
        check_eq("sv_idle", {31'd0, busy_a}, 32'd0);

        // Back-to-back fetches with MEM_LAT=1: acks 4 cycles apart
        if_req_b = 1'b1; if_addr_b = 32'h10;
        last_cyc = cyc;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (!if_ack_b && n < 10) begin
                tick(1);
                n = n + 1;
            end
            check_eq("b_ack_seen", {31'd0, if_ack_b}, 32'd1);
            check_eq($sformatf("b_spacing%0d", k), 32'(cyc - last_cyc),
                     (k == 0) ? 32'd3 : 32'd4);
            check_eq("b_rdata", if_rdata_b, 32'hDEAD_BEEF);
            last_cyc = cyc;
            if (k == 2) begin
                if_req_b = 1'b0;
            end
            tick(1);
        end
        check_eq("b_idle", {31'd0, busy_b}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
